// File: rtl/mem_wb_skid_reg.sv
// MEM->WB boundary register with valid/ready handshake.
// SKID=1: two-entry skid buffer, in_ready is a flop (no path from out_ready).
// SKID=0: single stall register, in_ready = !out_valid | out_ready.
// out_ctrl is forced to zero on bubbles so WB never sees a stale write enable.
module mem_wb_skid_reg #(
  parameter int DATA_W = 32,
  parameter int DEST_W = 4,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [DATA_W-1:0] in_value,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [DATA_W-1:0] out_value,
  output logic [DEST_W-1:0] out_dest,
  output logic [1:0]        occupancy
);

  // State code doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_d;
  logic              rdy_q;
  logic              accept;
  logic              consume;
  logic              load_main;
  logic              main_from_skid;
  logic              load_skid;

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_alu_res;
  logic [DATA_W-1:0] main_value;
  logic [DEST_W-1:0] main_dest;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_alu_res;
  logic [DATA_W-1:0] skid_value;
  logic [DEST_W-1:0] skid_dest;

  assign out_valid   = (state != ST_EMPTY);
  assign occupancy   = state;
  assign out_ctrl    = out_valid ? main_ctrl : '0;
  assign out_alu_res = main_alu_res;
  assign out_value   = main_value;
  assign out_dest    = main_dest;

  // rdy_q is low during reset and for the first edge after it; with SKID=1 it
  // is the whole in_ready, with SKID=0 it only gates the combinational term.
  assign in_ready = (SKID != 0) ? rdy_q : (rdy_q & (~out_valid | out_ready));
  assign accept   = in_valid & in_ready;
  assign consume  = out_valid & out_ready;

  // Next-state and entry-load decisions; flush wins over accept and consume.
  always_comb begin
    state_d        = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_d   = ST_ONE;
            load_main = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            load_main = 1'b1;
          end else if (accept && (SKID != 0)) begin
            state_d   = ST_TWO;
            load_skid = 1'b1;
          end else if (consume) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            state_d        = ST_ONE;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // State register and registered ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
      rdy_q <= 1'b0;
    end else begin
      state <= state_d;
      rdy_q <= (state_d != ST_TWO);
    end
  end

  // Head entry: loaded from the input or promoted from the skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl    <= '0;
      main_alu_res <= '0;
      main_value   <= '0;
      main_dest    <= '0;
    end else if (load_main) begin
      main_ctrl    <= main_from_skid ? skid_ctrl    : in_ctrl;
      main_alu_res <= main_from_skid ? skid_alu_res : in_alu_res;
      main_value   <= main_from_skid ? skid_value   : in_value;
      main_dest    <= main_from_skid ? skid_dest    : in_dest;
    end
  end

  // Second entry, only written when the head is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_ctrl    <= '0;
      skid_alu_res <= '0;
      skid_value   <= '0;
      skid_dest    <= '0;
    end else if (load_skid) begin
      skid_ctrl    <= in_ctrl;
      skid_alu_res <= in_alu_res;
      skid_value   <= in_value;
      skid_dest    <= in_dest;
    end
  end

endmodule

// File: doc/mem_wb_skid_reg.md
Name: mem_wb_skid_reg

Overview:
- Parametrised MEM->WB pipeline boundary register with a valid/ready handshake, an optional 2-entry skid buffer, and synchronous flush.
- Carries the control bits, ALU result, load/store value and destination register index from the MEM stage to the WB stage.
- Allows WB back-pressure (for example a register-file port conflict) without a combinational ready path back into MEM.
- Forces control bits to zero on bubbles, so WB never sees a stale write enable.

Parameters:
- DATA_W, 32, width of the alu_res and value fields.
- DEST_W, 4, width of the destination register index.
- CTRL_W, 2, width of the control vector; bit0 = wb_en, bit1 = mem_read_en.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single stall register with combinational in_ready.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream entry valid.
- in_ready  out  1  block can accept an entry this cycle.
- in_ctrl  in  CTRL_W  control bits.
- in_alu_res  in  DATA_W  ALU result.
- in_value  in  DATA_W  memory or store value.
- in_dest  in  DEST_W  destination register index.
- out_valid  out  1  output entry valid.
- out_ready  in  1  WB consumes the entry this cycle.
- out_ctrl  out  CTRL_W  control bits; zero whenever out_valid=0.
- out_alu_res  out  DATA_W  held ALU result.
- out_value  out  DATA_W  held value.
- out_dest  out  DEST_W  held destination index.
- occupancy  out  2  number of entries held (0..2).

Behaviour:
- Reset (async, asserted): all outputs 0, both entries empty, state EMPTY.
  - in_ready=1 one cycle after rst deasserts. It is 0 while rst is high.
- Handshakes: accept = in_valid & in_ready; consume = out_valid & out_ready, both sampled at the posedge.
- Ordering: strict FIFO. No entry is dropped, duplicated or reordered except by flush.
- Output fields come from the main (head) entry only.
- out_ctrl = main_ctrl when out_valid=1, else 0.
- Data fields keep their last value while invalid. They are don't-care, but must not be X after reset.
- SKID=1 states (main = head entry, skid = second entry):
  - EMPTY: accept -> ONE, load main.
  - ONE:
    - accept & consume -> ONE, main <= input.
    - accept & !consume -> TWO, skid <= input.
    - !accept & consume -> EMPTY.
    - otherwise hold.
  - TWO (in_ready=0):
    - consume -> ONE, main <= skid.
    - otherwise hold.
  - in_ready = (state != TWO). It is a registered output with no combinational path from out_ready.
  - Latency: accepted entry appears on outputs the next cycle when the block was EMPTY, or when it was ONE with a simultaneous consume. Throughput is 1 entry/cycle while out_ready=1.
- SKID=0:
  - Single entry. in_ready = !out_valid | out_ready (combinational).
  - States EMPTY and ONE only. occupancy never exceeds 1.
  - With out_ready tied 1, behaviour is cycle-identical to a plain enable-free pipeline register plus out_valid.
- Flush (synchronous, priority over accept and consume):
  - Next state EMPTY; out_valid=0; out_ctrl=0; occupancy=0.
  - The input presented in the flush cycle is discarded, even if in_ready=1.
  - Consume in the flush cycle is ignored; upstream must not count it.
- Simultaneous events:
  - rst overrides everything asynchronously.
  - Flush overrides accept and consume.
  - Accept plus consume in ONE keeps occupancy at 1.
- occupancy equals the number of held entries after each edge: EMPTY=0, ONE=1, TWO=2.

Test Plan:
- Reset mid-stream: hold 2 entries, pulse rst between edges -> out_valid=0, out_ctrl=0, occupancy=0 immediately; in_ready=1 on the first edge after release.
- Streaming, SKID=1, out_ready=1: feed dest=1..5 with alu_res=0x10..0x50 back-to-back -> outputs 1..5 on consecutive cycles, 1-cycle latency, in_ready stays 1.
- Back-pressure: feed A(dest=3, ctrl=01), B(dest=7, ctrl=11) with out_ready=0 -> occupancy=2, in_ready=0, out shows A. Raise out_ready -> A, then B, each presented 1 cycle; C is accepted only after in_ready rises.
- Flush while TWO with in_valid=1 (entry D) -> next cycle out_valid=0, out_ctrl=00, occupancy=0; D is never output.
- Bubble control gating: entry ctrl=01 consumed, then no input -> out_ctrl=00 while out_alu_res holds its last value; WB write enable never spuriously set.
- SKID=0 build: out_ready=0 with 1 entry held -> in_ready=0 in the same cycle. Assert out_ready and in_valid together -> the new entry replaces the old at the next edge.
